// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the sync_fifo_ext family.
package sync_fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_ext: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ext.sv
// Parametrised single-clock FIFO with STD/FWFT read modes, threshold flags and sticky error flags.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter fifo_mode_e  MODE     = FIFO_STD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     r_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Reject illegal geometry / thresholds at elaboration.
    initial begin : elab_checks
        assert (is_pow2(int'(DEPTH)) && (DEPTH >= 2))
            else $fatal(1, "sync_fifo_ext: DEPTH must be a power of two and >= 2");
        assert ((AE_LEVEL >= 1) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))
            else $fatal(1, "sync_fifo_ext: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [AW-1:0]    w_ptr_q, w_ptr_d;
    logic [AW-1:0]    r_ptr_q, r_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_we;
    logic [WIDTH-1:0] rdata;

    // Handshake acceptance and next-state for pointers, occupancy and flags.
    always_comb begin
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        w_ptr_d  = w_ptr_q;
        r_ptr_d  = r_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        // Acceptance looks only at registered full/empty, never at same-cycle traffic.
        wr_acc = w_en && !full_q;
        rd_acc = r_en && !empty_q;

        if (wr_acc) begin
            w_ptr_d = w_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + AW'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new rejection takes priority over a clear in the same cycle.
        if (w_en && full_q) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end
        if (r_en && empty_q) begin
            unf_d = 1'b1;
        end else if (err_clr) begin
            unf_d = 1'b0;
        end

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == CW'(0));
        afull_d  = (count_d >= CW'(AF_LEVEL));
        aempty_d = (count_d <= CW'(AE_LEVEL));
    end

    // State registers; flags are registered copies derived from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Reset must not disturb storage through a write accepted in the same cycle.
    assign mem_we = wr_acc && !reset;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (w_ptr_q),
        .wdata_i (din),
        .raddr_i (r_ptr_q),
        .rdata_o (rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] dout_q;

        // Output register loads the head word on an accepted read, holds otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rdata;
            end
        end

        assign dout = dout_q;
    end else begin : g_fwft
        assign dout = rdata;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench: one STD and one FWFT instance share stimulus; a queue model predicts both.
module tb_sync_fifo_ext;
    import sync_fifo_pkg::*;

    localparam int W   = 8;
    localparam int D   = 8;
    localparam int AFL = 6;
    localparam int AEL = 2;

    logic         clk = 1'b0;
    logic         reset, w_en, r_en, err_clr;
    logic [W-1:0] din;

    logic [W-1:0] s_dout, f_dout;
    logic         s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic         f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]   s_count, f_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] exp_std_q[$];
    logic [W-1:0] exp_fwft_q[$];
    logic         m_ovf, m_unf;
    logic [W-1:0] m_std_dout;

    always #5 clk = ~clk;

    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_STD)) u_std (
        .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .err_clr(err_clr),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .err_clr(err_clr),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] cnt, input logic e, input logic f,
                               input logic af, input logic ae, input logic ov, input logic un);
        int sz = m_q.size();
        check({tag, "_count"}, 32'(cnt), 32'(sz));
        check({tag, "_empty"}, 32'(e), 32'(sz == 0));
        check({tag, "_full"}, 32'(f), 32'(sz == D));
        check({tag, "_almost_full"}, 32'(af), 32'(sz >= AFL));
        check({tag, "_almost_empty"}, 32'(ae), 32'(sz <= AEL));
        check({tag, "_overflow"}, 32'(ov), 32'(m_ovf));
        check({tag, "_underflow"}, 32'(un), 32'(m_unf));
    endtask

    // Compare every visible output against the model as it stands after the last edge.
    task automatic check_state();
        check_flags("std", s_count, s_empty, s_full, s_af, s_ae, s_ovf, s_unf);
        check_flags("fwft", f_count, f_empty, f_full, f_af, f_ae, f_ovf, f_unf);
        check("std_dout_hold", 32'(s_dout), 32'(m_std_dout));
        if (m_q.size() != 0) check("fwft_head", 32'(f_dout), 32'(m_q[0]));
    endtask

    // FIFO semantics at the level of a queue: acceptance judged on occupancy before the edge.
    task automatic model_apply(input logic w, input logic [W-1:0] d, input logic r,
                               input logic c, input logic rs);
        int sz;
        logic [W-1:0] word;
        if (rs) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_std_dout = '0;
            return;
        end
        sz = m_q.size();
        m_ovf = (w && sz == D) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = (r && sz == 0) ? 1'b1 : (c ? 1'b0 : m_unf);
        if (r && sz > 0) begin
            word = m_q.pop_front();
            exp_std_q.push_back(word);
            exp_fwft_q.push_back(word);
            m_std_dout = word;
        end
        if (w && sz < D) m_q.push_back(d);
    endtask

    task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                        input logic c, input logic rs);
        @(posedge clk);
        #1;
        check_state();
        w_en = w; din = d; r_en = r; err_clr = c; reset = rs;
        model_apply(w, d, r, c, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: data checks triggered by the DUT handshakes, decoupled from stimulus.
    initial begin : monitor
        logic std_pending = 1'b0;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (std_pending) begin
                if (exp_std_q.size() == 0) check("std_scoreboard_underrun", 32'(1), 32'(0));
                else begin
                    e = exp_std_q.pop_front();
                    check("std_read_data", 32'(s_dout), 32'(e));
                end
            end
            if (r_en && !f_empty && !reset) begin
                if (exp_fwft_q.size() == 0) check("fwft_scoreboard_underrun", 32'(1), 32'(0));
                else begin
                    e = exp_fwft_q.pop_front();
                    check("fwft_read_data", 32'(f_dout), 32'(e));
                end
            end
            std_pending = r_en && !s_empty && !reset;
        end
    end

    initial begin : stimulus
        reset = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; din = '0;
        model_apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Fill 0x01..0x08, then a rejected 0xFF, then drain
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Read while empty, then clear both sticky flags
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Four words deep, then 20 cycles of simultaneous traffic across the wrap
        for (int i = 0; i < 4; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, W'(8'h20 + i), 1'b1, 1'b0, 1'b0);

        // Full with both requests, then empty with both requests
        for (int i = 0; i < 4; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // FWFT head visible before any read: reset, write 0xA5, idle, single read
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reset with five words stored, then a round trip
        for (int i = 0; i < 5; i++) step(1'b1, W'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Random traffic: write-biased phase, then read-biased phase
        for (int i = 0; i < 600; i++) begin
            int wp = (i < 300) ? 70 : 30;
            step(1'($urandom_range(0, 99) < wp),
                 W'($urandom),
                 1'($urandom_range(0, 99) < (100 - wp)),
                 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 199) == 0));
        end
        idle(4);

        check("std_scoreboard_drained", 32'(exp_std_q.size()), 32'(0));
        check("fwft_scoreboard_drained", 32'(exp_fwft_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
